// File: rtl/rca_ctrl_pkg.sv
// Purpose : shared types and constants for the ripple-carry-adder self-test/repair controller.
// Contents: FSM state enum, exhaustive vector count, APPLY settle length.
// Users   : rca_repair_ctrl (top).
package rca_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } rca_state_e;

  // Exhaustive test of a full adder: every {a,b,cin} combination.
  localparam int NUM_VECTORS   = 8;
  // Cycles a vector is held on the slice before its outputs are sampled.
  localparam int SETTLE_CYCLES = 1;

endpackage

// File: rtl/fa_golden.sv
// Purpose : reference full adder producing the expected slice response.
// Ports   : a, b, cin in; sum, cout out.
// Latency : combinational.
module fa_golden (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/rca_repair_ctrl.sv
// Purpose : self-tests WIDTH full-adder slices plus one spare, then steers bits around
//           the first faulty slice via sel (sel[j]=1 routes bit j through slice j+1).
// Ports   : clk/rst_n; start request; test_* vector bus to/from the slice under test;
//           sel repair mux selects; busy/done/fault_found/fault_idx/unrepairable status.
// Option  : RCA_CTRL_PERIODIC_EN adds an idle counter that self-starts a test after
//           PERIOD consecutive idle cycles.
module rca_repair_ctrl #(
  parameter int WIDTH  = 8,
  parameter int PERIOD = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         test_mode,
  output logic [$clog2(WIDTH+1)-1:0]   test_sel,
  output logic                         test_a,
  output logic                         test_b,
  output logic                         test_cin,
  input  logic                         test_sum,
  input  logic                         test_cout,
  output logic [WIDTH-1:0]             sel,
  output logic                         busy,
  output logic                         done,
  output logic                         fault_found,
  output logic [$clog2(WIDTH+1)-1:0]   fault_idx,
  output logic                         unrepairable
);

  import rca_ctrl_pkg::*;

  localparam int IDXW = $clog2(WIDTH + 1);

  rca_state_e        state_q, state_d;
  logic [IDXW-1:0]   slice_q, slice_d;
  logic [2:0]        vec_q, vec_d;
  logic [3:0]        settle_q, settle_d;
  logic              test_mode_q, test_mode_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  sel_q, sel_d;
  logic              fault_found_q, fault_found_d;
  logic [IDXW-1:0]   fault_idx_q, fault_idx_d;
  logic              unrep_q, unrep_d;

  logic              exp_sum, exp_cout;
  logic              mismatch;
  logic              go;
  logic [WIDTH-1:0]  repair_sel;

  // slice_q and vec_q are parked at 0 outside a test, so the vector bus reads 0
  // whenever test_mode is low without extra gating.
  assign test_mode    = test_mode_q;
  assign test_sel     = slice_q;
  assign test_a       = vec_q[2];
  assign test_b       = vec_q[1];
  assign test_cin     = vec_q[0];
  assign sel          = sel_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fault_found  = fault_found_q;
  assign fault_idx    = fault_idx_q;
  assign unrepairable = unrep_q;

  fa_golden u_fa_golden (
    .a    (vec_q[2]),
    .b    (vec_q[1]),
    .cin  (vec_q[0]),
    .sum  (exp_sum),
    .cout (exp_cout)
  );

  assign mismatch = (test_sum != exp_sum) || (test_cout != exp_cout);

`ifdef RCA_CTRL_PERIODIC_EN
  localparam int CNTW = $clog2(PERIOD + 1);

  logic [CNTW-1:0] idle_cnt_q, idle_cnt_d;
  logic            auto_start;

  // Counter only runs while idle; any start (external or automatic) rewinds it.
  assign auto_start = (state_q == ST_IDLE) && (idle_cnt_q == CNTW'(PERIOD - 1));
  assign go         = start || auto_start;

  always_comb begin
    idle_cnt_d = idle_cnt_q + 1'b1;
    if (state_q != ST_IDLE || go) idle_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`else
  localparam int unused_period = PERIOD;

  assign go = start;
`endif

  // Repair map: shift every bit at or above the faulty slice up by one. A fault
  // in the spare (index WIDTH) leaves no j >= fault_idx, so sel stays 0.
  always_comb begin
    for (int j = 0; j < WIDTH; j++) begin
      repair_sel[j] = fault_found_q && !unrep_q && (IDXW'(j) >= fault_idx_q);
    end
  end

  always_comb begin
    state_d       = state_q;
    slice_d       = slice_q;
    vec_d         = vec_q;
    settle_d      = settle_q;
    test_mode_d   = test_mode_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    sel_d         = sel_q;
    fault_found_d = fault_found_q;
    fault_idx_d   = fault_idx_q;
    unrep_d       = unrep_q;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d       = ST_APPLY;
          slice_d       = '0;
          vec_d         = '0;
          settle_d      = '0;
          test_mode_d   = 1'b1;
          busy_d        = 1'b1;
          fault_found_d = 1'b0;
          fault_idx_d   = '0;
          unrep_d       = 1'b0;
        end
      end

      ST_APPLY: begin
        if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
          state_d  = ST_CHECK;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          if (!fault_found_q) begin
            fault_found_d = 1'b1;
            fault_idx_d   = slice_q;
          end else begin
            unrep_d = 1'b1;
          end
        end

        // A failing slice is already condemned, so its remaining vectors are skipped.
        if (!mismatch && (vec_q != 3'(NUM_VECTORS - 1))) begin
          vec_d   = vec_q + 3'd1;
          state_d = ST_APPLY;
        end else if (slice_q == IDXW'(WIDTH)) begin
          state_d     = ST_DONE;
          slice_d     = '0;
          vec_d       = '0;
          test_mode_d = 1'b0;
          busy_d      = 1'b0;
        end else begin
          slice_d = slice_q + 1'b1;
          vec_d   = '0;
          state_d = ST_APPLY;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        sel_d   = repair_sel;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      slice_q       <= '0;
      vec_q         <= '0;
      settle_q      <= '0;
      test_mode_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      sel_q         <= '0;
      fault_found_q <= 1'b0;
      fault_idx_q   <= '0;
      unrep_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      slice_q       <= slice_d;
      vec_q         <= vec_d;
      settle_q      <= settle_d;
      test_mode_q   <= test_mode_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      sel_q         <= sel_d;
      fault_found_q <= fault_found_d;
      fault_idx_q   <= fault_idx_d;
      unrep_q       <= unrep_d;
    end
  end

endmodule

// File: tb/tb_rca_repair_ctrl.sv
// Purpose : directed self-checking bench for rca_repair_ctrl (WIDTH=8, default build).
// Model   : behavioural slices with per-slice stuck-at-0 sum / stuck-at-1 cout faults.
// Output  : FAIL lines per mismatch and one pass/total summary line.
module tb_rca_repair_ctrl;

  localparam int W  = 8;
  localparam int IW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          test_mode;
  logic [IW-1:0] test_sel;
  logic          test_a, test_b, test_cin;
  logic          test_sum, test_cout;
  logic [W-1:0]  sel;
  logic          busy, done, fault_found, unrepairable;
  logic [IW-1:0] fault_idx;

  logic [W:0]    sum_s0 = '0;
  logic [W:0]    cout_s1 = '0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign test_sum  = (test_a ^ test_b ^ test_cin) & ~sum_s0[test_sel];
  assign test_cout = ((test_a & test_b) | (test_a & test_cin) | (test_b & test_cin))
                     | cout_s1[test_sel];

  rca_repair_ctrl #(.WIDTH(W), .PERIOD(1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .test_mode    (test_mode),
    .test_sel     (test_sel),
    .test_a       (test_a),
    .test_b       (test_b),
    .test_cin     (test_cin),
    .test_sum     (test_sum),
    .test_cout    (test_cout),
    .sel          (sel),
    .busy         (busy),
    .done         (done),
    .fault_found  (fault_found),
    .fault_idx    (fault_idx),
    .unrepairable (unrepairable)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Pulses start, then follows the test edge by edge (sampled 1ns after each edge).
  // cycles = first edge after the accepting edge at which done is seen (0 = never).
  task automatic run_test(input bit repulse, output int cycles, output int n_done,
                          output logic busy_mid, output logic [W-1:0] sel_mid,
                          output logic ff_acc);
    cycles   = 0;
    n_done   = 0;
    busy_mid = 1'b0;
    sel_mid  = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    ff_acc = fault_found;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      start = repulse && (c == 10 || c == 100);
      if (c == 50) begin
        busy_mid = busy;
        sel_mid  = sel;
      end
      if (done) begin
        n_done++;
        if (cycles == 0) cycles = c;
      end
      if (!repulse && n_done != 0) break;
    end
    start = 1'b0;
  endtask

  int            cyc, nd;
  logic          bm, ffa;
  logic [W-1:0]  sm;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sel",   32'(sel), 32'h00);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_tmode", 32'(test_mode), 0);
    check("rst_flags", 32'({fault_found, unrepairable, fault_idx}), 0);
    check("rst_tbus",  32'({test_sel, test_a, test_b, test_cin}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fault-free run
    run_test(1'b0, cyc, nd, bm, sm, ffa);
    check("ok_latency", 32'(cyc), 145);
    check("ok_busy_mid", 32'(bm), 1);
    check("ok_sel", 32'(sel), 32'h00);
    check("ok_ff", 32'(fault_found), 0);
    check("ok_unrep", 32'(unrepairable), 0);
    check("ok_tmode_after", 32'({test_mode, busy, test_sel, test_a, test_b, test_cin}), 0);
    @(posedge clk);
    #1;
    check("ok_done_1cyc", 32'(done), 0);

    // Slice 3 sum stuck-at-0
    sum_s0 = 9'b0_0000_1000;
    run_test(1'b0, cyc, nd, bm, sm, ffa);
    check("s3_done_seen", 32'(nd), 1);
    check("s3_sel_mid", 32'(sm), 32'h00);
    check("s3_ff", 32'(fault_found), 1);
    check("s3_idx", 32'(fault_idx), 3);
    check("s3_sel", 32'(sel), 32'hF8);
    check("s3_unrep", 32'(unrepairable), 0);

    // Spare slice cout stuck-at-1
    sum_s0  = '0;
    cout_s1 = 9'b1_0000_0000;
    run_test(1'b0, cyc, nd, bm, sm, ffa);
    check("sp_ff_clear", 32'(ffa), 0);
    check("sp_sel_hold", 32'(sm), 32'hF8);
    check("sp_ff", 32'(fault_found), 1);
    check("sp_idx", 32'(fault_idx), 8);
    check("sp_sel", 32'(sel), 32'h00);
    check("sp_unrep", 32'(unrepairable), 0);

    // Slices 2 and 5 faulty
    sum_s0  = 9'b0_0000_0100;
    cout_s1 = 9'b0_0010_0000;
    run_test(1'b0, cyc, nd, bm, sm, ffa);
    check("dbl_ff", 32'(fault_found), 1);
    check("dbl_idx", 32'(fault_idx), 2);
    check("dbl_unrep", 32'(unrepairable), 1);
    check("dbl_sel", 32'(sel), 32'h00);

    // Slice 4 fault to establish sel=F0
    sum_s0  = 9'b0_0001_0000;
    cout_s1 = '0;
    run_test(1'b0, cyc, nd, bm, sm, ffa);
    check("s4_sel", 32'(sel), 32'hF0);

    // Reset at cycle 40 of a fault-free test
    sum_s0 = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    check("ab_sel_before", 32'(sel), 32'hF0);
    #3;
    rst_n = 1'b0;
    #1;
    check("ab_sel", 32'(sel), 32'h00);
    check("ab_busy_tmode", 32'({busy, test_mode}), 0);
    check("ab_flags", 32'({done, fault_found, unrepairable, fault_idx}), 0);
    check("ab_tbus", 32'({test_sel, test_a, test_b, test_cin}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_test(1'b0, cyc, nd, bm, sm, ffa);
    check("ab_rerun_latency", 32'(cyc), 145);
    check("ab_rerun_ff", 32'(fault_found), 0);

    // start re-pulsed mid-test must be ignored
    run_test(1'b1, cyc, nd, bm, sm, ffa);
    check("rp_latency", 32'(cyc), 145);
    check("rp_single_done", 32'(nd), 1);
    check("rp_idle_after", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rca_repair_ctrl.md
RCA_REPAIR_CTRL -- requirements
Module: rca_repair_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of primary full-adder slices; slice index WIDTH is the spare.
REQ-002 SHALL have parameter PERIOD, default 1024: idle cycles between automatic re-tests; used only with RCA_CTRL_PERIODIC_EN.
REQ-003 SHALL have ports:
 clk  in  1  rising-edge clock
 rst_n  in  1  reset, asynchronous, active-low
 start  in  1  request self-test and repair
 test_mode  out  1  high while slices are under test
 test_sel  out  $clog2(WIDTH+1)  slice under test, 0..WIDTH
 test_a, test_b, test_cin  out  1 each  vector driven to the selected slice
 test_sum, test_cout  in  1 each  observed outputs of the selected slice
 sel  out  WIDTH  mux selects; sel[j]=1 routes bit j through slice j+1
 busy  out  1  test in progress
 done  out  1  one-cycle pulse at test completion
 fault_found  out  1  at least one faulty slice detected
 fault_idx  out  $clog2(WIDTH+1)  index of the first faulty slice
 unrepairable  out  1  two or more faulty slices detected

Function
REQ-004 SHALL implement the FSM states IDLE, APPLY, CHECK and DONE.
REQ-005 IDLE->APPLY SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-006 APPLY SHALL drive vector v (0..7) as {test_a,test_b,test_cin}=v to slice test_sel for one settle cycle, then go to CHECK.
REQ-007 CHECK SHALL compare test_sum with a^b^cin and test_cout with maj(a,b,cin).
 - Match with v<7: v+1 -> APPLY.
 - Match with v=7, or mismatch: advance to the next slice with v=0; on a mismatch, remaining vectors of that slice are skipped.
REQ-008 Slices SHALL be tested in order 0..WIDTH; after slice WIDTH, go to DONE.
REQ-009 On the first mismatch, the block SHALL set fault_found=1 and fault_idx=slice; on a second faulty slice it SHALL set unrepairable=1.
REQ-010 DONE SHALL pulse done for one cycle, load sel, then return to IDLE.
 - Repairable fault at k<WIDTH: sel[j]=1 for j>=k, else 0.
 - Fault-free, spare-only fault, or unrepairable: sel=0.
REQ-011 sel SHALL hold its previous value throughout a test; fault_found, fault_idx and unrepairable SHALL clear on start acceptance and hold after DONE.
REQ-012 test_mode and busy SHALL be high in APPLY and CHECK only; the test_* outputs SHALL be 0 when test_mode=0.
REQ-013 With no fault, done SHALL assert exactly (WIDTH+1)*16+1 cycles after the start-accepting edge (145 for WIDTH=8).

Reset
REQ-014 rst_n low SHALL asynchronously force: state IDLE; sel, fault_found, fault_idx, unrepairable, busy, done, test_mode and test_* all 0.
REQ-015 Reset mid-test SHALL abort the test with no partial sel update; the first start after release SHALL begin a full test from slice 0.

Configuration
REQ-016 With RCA_CTRL_PERIODIC_EN defined, the block SHALL include an idle counter that self-starts a test after PERIOD consecutive IDLE cycles; the counter SHALL reset on every start.
REQ-017 Without RCA_CTRL_PERIODIC_EN, tests SHALL start only on start, PERIOD SHALL have no effect, and no counter logic SHALL exist.

Structure
REQ-018 Package rca_ctrl_pkg SHALL hold the FSM state enum, the vector-count constant (8) and the settle-cycle constant (1).
REQ-019 The expected sum/cout computation SHALL be the sub-module fa_golden (inputs a, b, cin; outputs sum, cout), instantiated once.

Verification
REQ-020 Fault-free model, WIDTH=8, start pulse -> done at cycle 145; sel=8'h00, fault_found=0, unrepairable=0.
REQ-021 Slice 3 test_sum stuck-at-0 -> fault_idx=3, fault_found=1, sel=8'b1111_1000, unrepairable=0.
REQ-022 Spare slice 8 test_cout stuck-at-1 -> fault_found=1, fault_idx=8, sel=8'h00, unrepairable=0.
REQ-023 Slices 2 and 5 faulty -> fault_idx=2, unrepairable=1, sel=8'h00.
REQ-024 rst_n low at cycle 40 of a test with prior sel=8'hF0 -> all outputs 0 immediately; a new start completes in 145 cycles.
REQ-025 start re-pulsed at cycle 10 and cycle 100 -> ignored; a single done at cycle 145.
